// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the oversampling UART receiver: serial line and
// frame configuration in, received byte and per-frame strobes out.
interface uart_rx_if #(
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] PRESCALE;
  logic [7:0]                P_DATA;
  logic                      DATA_VALID;
  logic                      PAR_ERR;
  logic                      STP_ERR;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch filter, 3-sample majority vote
// at mid-bit, 8 data bits LSB first, optional parity, stop check.
module uart_rx #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);
  localparam int            PW  = PRESCALE_WIDTH;
  localparam logic [PW-1:0] ONE = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pres_q;
  logic [PW-1:0] edge_cnt_q, edge_cnt_d;
  logic [PW-1:0] half;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic [2:0]    samp_q;
  logic          par_en_q, par_typ_q, par_bad_q;
  logic [7:0]    p_data_q;
  logic          dv_q, pe_q, se_q;

  logic start_det, last_edge, bit_val, exp_par;
  logic cnt_run, shift_en, par_chk, frame_done, frame_ok;

  assign half      = pres_q >> 1;
  assign start_det = (state_q == S_IDLE) && !bus.RX_IN;
  assign last_edge = (edge_cnt_q == pres_q - ONE);
  assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                     (samp_q[1] & samp_q[2]);
  assign exp_par   = par_typ_q ? ~^shreg_q : ^shreg_q;
  assign frame_ok  = frame_done && !par_bad_q && bit_val;

  // The detecting IDLE cycle is edge 0 of the start bit, so counting resumes at 1.
  assign edge_cnt_d = start_det              ? ONE :
                      (cnt_run && !last_edge) ? edge_cnt_q + ONE : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!bus.RX_IN) state_d = S_START;
      S_START:  if (last_edge) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA:   if (last_edge && bit_cnt_q == 3'd7)
                  state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (last_edge) state_d = S_STOP;
      S_STOP:   if (last_edge) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_run    = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_START:  cnt_run = 1'b1;
      S_DATA:   begin cnt_run = 1'b1; shift_en   = last_edge; end
      S_PARITY: begin cnt_run = 1'b1; par_chk    = last_edge; end
      S_STOP:   begin cnt_run = 1'b1; frame_done = last_edge; end
      default:  cnt_run = 1'b0;
    endcase
  end

  // Frame configuration is frozen at start detection for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pres_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (start_det) begin
      pres_q    <= bus.PRESCALE;
      par_en_q  <= bus.PAR_EN;
      par_typ_q <= bus.PAR_TYP;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      samp_q     <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      if (cnt_run) begin
        if (edge_cnt_q == half - ONE) samp_q[0] <= bus.RX_IN;
        if (edge_cnt_q == half)       samp_q[1] <= bus.RX_IN;
        if (edge_cnt_q == half + ONE) samp_q[2] <= bus.RX_IN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      if (start_det) begin
        bit_cnt_q <= '0;
        par_bad_q <= 1'b0;
      end
      if (shift_en) begin
        shreg_q[bit_cnt_q] <= bit_val;
        bit_cnt_q          <= bit_cnt_q + 3'd1;
      end
      if (par_chk) par_bad_q <= (bit_val != exp_par);
    end
  end

  // Strobes go out the cycle after the stop bit's last edge; P_DATA only moves on a clean frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_data_q <= '0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      dv_q <= frame_ok;
      pe_q <= frame_done && par_bad_q;
      se_q <= frame_done && !bit_val;
      if (frame_ok) p_data_q <= shreg_q;
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = dv_q;
  assign bus.PAR_ERR    = pe_q;
  assign bus.STP_ERR    = se_q;
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are built from bit lists,
// expected strobes (cycle, flags, byte) are queued and matched by a monitor.
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.PRESCALE_WIDTH(6)) bus();
  uart_rx #(.PRESCALE_WIDTH(6)) dut (.CLK(clk), .RST(rst_n), .bus(bus));

  typedef struct {
    logic [7:0] pdata;
    logic       dv;
    logic       pe;
    logic       se;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;
  int         ps[3] = '{8, 16, 32};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got dv=%0b pe=%0b se=%0b expected none at cycle %0d",
                   bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("data_valid", int'(bus.DATA_VALID), int'(e.dv));
          chk("par_err", int'(bus.PAR_ERR), int'(e.pe));
          chk("stp_err", int'(bus.STP_ERR), int'(e.se));
          chk("p_data", int'(bus.P_DATA), int'(e.pdata));
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
        checks++; errors++;
        $display("FAIL missing_strobe: got none expected strobe at cycle %0d", sbq[0].cyc);
        sbq.delete(0);
      end
    end
  end

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Serialises one frame; the expected outcome comes straight from the bit list.
  task automatic send_frame(input logic [7:0] d, input int p, input bit pen,
                            input bit ptyp, input bit pflip, input bit stop,
                            input int spike_bit, input bit scramble);
    logic bits[$];
    exp_t e;
    logic pbit;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) begin
      pbit = (ptyp ? ~^d : ^d) ^ pflip;
      bits.push_back(pbit);
    end
    bits.push_back(stop);
    bus.PRESCALE = 6'(p);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    e.pe  = pen && pflip;
    e.se  = !stop;
    e.dv  = !e.pe && !e.se;
    e.cyc = cyc + bits.size() * p;
    if (e.dv) last_good = d;
    e.pdata = last_good;
    sbq.push_back(e);
    for (int k = 0; k < bits.size(); k++) begin
      for (int t = 0; t < p; t++) begin
        bus.RX_IN = (k == spike_bit && t == p / 2) ? ~bits[k] : bits[k];
        if (scramble && k == 0 && t == 1) begin
          bus.PRESCALE = 6'(ps[$urandom_range(0, 2)]);
          bus.PAR_EN   = 1'($urandom_range(0, 1));
          bus.PAR_TYP  = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    bus.RX_IN = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    chk("p_data_stable", int'(bus.P_DATA), int'(last_good));
  endtask

  initial begin
    logic [7:0] dd;
    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.PRESCALE = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p_data", int'(bus.P_DATA), 0);
    chk("rst_data_valid", int'(bus.DATA_VALID), 0);
    chk("rst_par_err", int'(bus.PAR_ERR), 0);
    chk("rst_stp_err", int'(bus.STP_ERR), 0);
    rst_n = 1'b1;
    idle(4);

    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    drain(200);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    drain(200);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    drain(200);
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    drain(200);

    // Short low glitch, then a real frame exactly 16 cycles after it began.
    bus.PRESCALE = 6'd16; bus.PAR_EN = 1'b0;
    bus.RX_IN = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    idle(13);
    send_frame(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    drain(200);
    send_frame(8'h5B, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    drain(200);

    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    drain(400);

    // Abort a frame mid bit 4 with reset, then receive a clean one.
    bus.PRESCALE = 6'd16; bus.PAR_EN = 1'b0;
    dd = 8'hC3;
    for (int c = 0; c < 4 * 16 + 8; c++) begin
      bus.RX_IN = (c < 16) ? 1'b0 : dd[(c / 16) - 1];
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    last_good = 8'h00;
    @(posedge clk); #1;
    chk("abort_p_data", int'(bus.P_DATA), 0);
    chk("abort_data_valid", int'(bus.DATA_VALID), 0);
    bus.RX_IN = 1'b1;
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    drain(400);

    for (int i = 0; i < 30; i++) begin
      int p, sb, nb;
      bit pen, ptyp, pflip, stp;
      logic [7:0] d8;
      p     = ps[$urandom_range(0, 2)];
      pen   = 1'($urandom_range(0, 1));
      ptyp  = 1'($urandom_range(0, 1));
      pflip = ($urandom_range(0, 4) == 0);
      stp   = ($urandom_range(0, 4) != 0);
      d8    = 8'($urandom_range(0, 255));
      nb    = pen ? 11 : 10;
      sb    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb - 1)) : -1;
      send_frame(d8, p, pen, ptyp, pflip, stp, sb, 1'b1);
      idle(int'($urandom_range(0, 3)));
    end
    drain(800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the receive-side counterpart of the transmitter; it consumes the serial line a UART transmitter drives. It detects a start bit, majority-samples each bit at mid-period, and deserializes 8 data bits LSB first. It optionally checks a parity bit and checks the stop bit, then presents the byte with a one-cycle valid strobe and error flags to the downstream register/control logic.

## Interface
- PRESCALE_WIDTH, 6, width of the PRESCALE input.
- CLK  in  1  receive clock; runs at PRESCALE × baud rate.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line; idle high. Already synchronized to CLK upstream.
- PAR_EN  in  1  1 = frame carries a parity bit after the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- PRESCALE  in  PRESCALE_WIDTH  oversampling ratio. Supported values are 8, 16 and 32; other values are not supported and are not driven.
- P_DATA  out  8  last correctly received byte.
- DATA_VALID  out  1  one-cycle strobe: the byte in P_DATA is new and error-free.
- PAR_ERR  out  1  one-cycle strobe: parity mismatch in the finished frame.
- STP_ERR  out  1  one-cycle strobe: stop bit sampled as 0 in the finished frame.

## Operation
- All outputs are registered. On reset every output is 0 and the FSM is in IDLE.
- PAR_EN, PAR_TYP and PRESCALE are latched on the cycle the start is detected and are held for the whole frame. Changes to them mid-frame have no effect.
- edge_cnt counts 0..P-1 within each bit, where P is the latched PRESCALE. bit_cnt counts data bits 0..7.
- Sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples and is usable from edge_cnt = P/2+2.
- FSM states:
  - IDLE: the first cycle with RX_IN=0 is edge 0 of the start bit; go to START.
  - START: at edge P-1, a sampled 0 goes to DATA. A sampled 1 is a glitch: return to IDLE silently, with no strobe and no error.
  - DATA: at edge P-1, shift the sampled bit into the shift register at bit position bit_cnt (LSB first). After bit 7, go to PARITY if PAR_EN, else to STOP.
  - PARITY: expected parity = ^data for even, ~^data for odd. Record a mismatch flag. At edge P-1, go to STOP.
  - STOP: at edge P-1, evaluate the frame and return to IDLE.
- Frame evaluation, registered so outputs change on the next cycle:
  - No errors: P_DATA <= shift register, DATA_VALID=1.
  - Otherwise: PAR_ERR and/or STP_ERR = 1, DATA_VALID=0, and P_DATA keeps its old value.
- Parity and stop errors can both be flagged in the same cycle.
- Strobes last exactly one cycle. P_DATA is stable between valid frames.
- Back-to-back frames: IDLE is re-entered the cycle after stop edge P-1. A start edge arriving then is detected with no lost frame.
- A stop error with the line held low: IDLE sees RX_IN=0 and begins a new start check. The glitch filter rejects it unless the line is still low at start edge P-1.
- Asserting RST mid-frame aborts the frame immediately. No strobes are generated for the aborted frame.

## Timing
- Cycle 0 is the first cycle RX_IN=0 in IDLE.
- Without parity, the frame occupies cycles 0..10P-1 and the strobes are high in cycle 10P. Example: P=8 gives DATA_VALID in cycle 80.
- With parity, the frame occupies cycles 0..11P-1 and the strobes are high in cycle 11P. Example: P=16 gives cycle 176.
- Bit k of the frame (start = 0) is sampled at cycles kP+P/2-1 .. kP+P/2+1.
- No backpressure: the consumer must accept the DATA_VALID strobe in the cycle it is high.

## Test plan
- P=8, PAR_EN=0, frame 0xA5 → DATA_VALID=1 exactly in cycle 80, P_DATA=0xA5, PAR_ERR=STP_ERR=0.
- P=16, PAR_EN=1, PAR_TYP=0:
  - 0x3C with parity bit 0 → DATA_VALID in cycle 176, P_DATA=0x3C.
  - 0x3C with parity bit 1 → PAR_ERR=1 in cycle 176, DATA_VALID=0, P_DATA unchanged.
- P=8, PAR_EN=1, PAR_TYP=1, 0x01 sent with stop bit 0 → PAR_ERR=0, STP_ERR=1 in cycle 88, DATA_VALID=0.
- P=16, a 3-cycle low glitch on an idle line → no strobes, and the FSM is back in IDLE by cycle 16. A single-cycle low spike inside a data bit at edge P/2 → majority rejects it and the byte is correct.
- P=32, frames 0x00, 0xFF, 0x5A back-to-back with no idle gap → three DATA_VALID pulses spaced exactly 320 cycles apart, each with the correct byte.
- RST asserted in the middle of bit 4, then a full frame 0x81 → no strobe from the aborted frame, and 0x81 is received correctly.
